button_conditioner: RTL



---
 rtl/button_pkg.sv | 19 +
 rtl/debounce_channel.sv | 93 +++++++++
 rtl/button_conditioner.sv | 37 +++
 3 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and channel indices for the button front end
//
// Contents:
//   db_state_t            per-channel debounce FSM state
//   BTN_CLEAR/START/STOP  bit positions of each button in the btn_in vector
package button_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int BTN_CLEAR = 0;
  localparam int BTN_START = 1;
  localparam int BTN_STOP  = 2;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchroniser, debounce FSM and counter for one button
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   btn_in   raw asynchronous bouncing button, active-high
//   level    debounced button state (registered)
//   tick     one-cycle pulse on each accepted press (registered)
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_TICKS  = 2_000_000,
  parameter int CNT_WIDTH = $clog2(DB_TICKS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic level,
  output logic tick
);

  // Terminal count of the stability window; exact-equality compare means the
  // counter never has to hold a value above this, so it cannot wrap.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DB_TICKS - 1);

  logic                 sync1;
  logic                 sync2;
  db_state_t            state;
  logic [CNT_WIDTH-1:0] cnt;

  // Two-flop synchroniser; sync1 may go metastable, only sync2 is used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      tick  <= 1'b0;
    end else begin
      // tick is a pulse: only the accepting transition below raises it.
      tick <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync2) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            // Bounce: abandon the window, it restarts on the next high sample.
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            level <= 1'b1;
            tick  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        IDLE_HIGH: begin
          if (!sync2) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // Release is accepted silently; only presses generate events.
            state <= IDLE_LOW;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel push-button synchroniser and debouncer
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   btn_in     raw buttons [NUM_BTN-1:0]; bit 0 clear, 1 start, 2 stop
//   btn_level  debounced button states (registered)
//   btn_tick   one-cycle press pulses (registered); one pulse per physical press
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BTN   = 3,
  parameter int DB_TICKS  = 2_000_000,
  parameter int CNT_WIDTH = $clog2(DB_TICKS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_tick
);

  // Channels are fully independent; no state is shared between them.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DB_TICKS  (DB_TICKS),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_in  (btn_in[i]),
      .level   (btn_level[i]),
      .tick    (btn_tick[i])
    );
  end

endmodule
